// File: rtl/game_pkg.sv
// Shared game constants, state encoding and LFSR step used by the controller,
// pipe_gen and the renderer.
package game_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PLAYING = 2'd1,
    S_DYING   = 2'd2,
    S_OVER    = 2'd3
  } state_t;

  localparam int SCREEN_H = 480;
  localparam int GROUND_H = 40;
  localparam int BIRD_X   = 160;
  localparam int BIRD_W   = 34;
  localparam int BIRD_H   = 24;
  localparam int PIPE_W   = 52;
  localparam int GAP_H    = 120;

  localparam logic [15:0] LFSR_INIT = 16'hACE1;
  localparam logic [15:0] SEED_INIT = 16'h1234;
  localparam logic [11:0] BCD_MAX   = 12'h999;

  // Fibonacci form, taps 16,14,13,11 counted from the shift-out end (bit 0).
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
  endfunction

endpackage

// File: rtl/bcd_counter3.sv
// Three-digit BCD up-counter with synchronous clear, saturating at 999.
module bcd_counter3
  import game_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        inc,
  output logic [11:0] count
);

  function automatic logic [11:0] bcd_inc(input logic [11:0] v);
    logic [11:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (carry) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && count != BCD_MAX) begin
      count <= bcd_inc(count);
    end
  end

endmodule

// File: rtl/game_ctrl.sv
// Flappy-Bird game controller: game FSM, per-frame collision check, BCD score,
// high score and the seed LFSR feeding pipe_gen.
module game_ctrl
  import game_pkg::*;
#(
  parameter int SCREEN_H     = game_pkg::SCREEN_H,
  parameter int GROUND_H     = game_pkg::GROUND_H,
  parameter int BIRD_X       = game_pkg::BIRD_X,
  parameter int BIRD_W       = game_pkg::BIRD_W,
  parameter int BIRD_H       = game_pkg::BIRD_H,
  parameter int PIPE_W       = game_pkg::PIPE_W,
  parameter int GAP_H        = game_pkg::GAP_H,
  parameter int DEATH_FRAMES = 30
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_en,
  input  logic        btn_flap,
  input  logic [11:0] bird_y,
  input  logic [11:0] pipe1_x,
  input  logic [11:0] pipe1_gap_y,
  input  logic [11:0] pipe2_x,
  input  logic [11:0] pipe2_gap_y,
  input  logic        score_pulse,
  output logic        game_active,
  output logic [15:0] random_seed,
  output logic        bird_reset,
  output logic        collision,
  output logic [1:0]  state,
  output logic [11:0] score_bcd,
  output logic [11:0] high_bcd
);

  localparam int          CW       = $clog2(DEATH_FRAMES + 1);
  localparam logic [12:0] GROUND_Y = 13'(SCREEN_H - GROUND_H);

  state_t        st;
  logic [15:0]   lfsr;
  logic [CW-1:0] death_cnt;
  logic          hit;
  logic          score_clr;
  logic          score_inc;

  // All geometry is widened to 13 bits so edge sums never wrap.
  function automatic logic pipe_hit(input logic [11:0] by, input logic [11:0] px,
                                    input logic [11:0] gy);
    logic [12:0] b, x, g;
    logic        x_ov, y_ov;
    b    = {1'b0, by};
    x    = {1'b0, px};
    g    = {1'b0, gy};
    x_ov = (x < 13'(BIRD_X + BIRD_W)) && (x + 13'(PIPE_W) > 13'(BIRD_X));
    y_ov = (b < g) || (b + 13'(BIRD_H) > g + 13'(GAP_H));
    return x_ov && y_ov;
  endfunction

  assign hit = ({1'b0, bird_y} + 13'(BIRD_H) > GROUND_Y)
             || pipe_hit(bird_y, pipe1_x, pipe1_gap_y)
             || pipe_hit(bird_y, pipe2_x, pipe2_gap_y);

  assign score_clr = (st == S_IDLE) && btn_flap;
  assign score_inc = (st == S_PLAYING) && score_pulse;
  assign state     = st;

  bcd_counter3 u_score (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (score_clr),
    .inc   (score_inc),
    .count (score_bcd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st          <= S_IDLE;
      game_active <= 1'b0;
      bird_reset  <= 1'b0;
      collision   <= 1'b0;
      high_bcd    <= '0;
      random_seed <= SEED_INIT;
      lfsr        <= LFSR_INIT;
      death_cnt   <= '0;
    end else begin
      lfsr       <= lfsr_next(lfsr);
      bird_reset <= 1'b0;
      collision  <= 1'b0;
      case (st)
        S_IDLE: begin
          if (btn_flap) begin
            st          <= S_PLAYING;
            game_active <= 1'b1;
            bird_reset  <= 1'b1;
            random_seed <= lfsr;
          end
        end
        S_PLAYING: begin
          if (frame_en && hit) begin
            st          <= S_DYING;
            game_active <= 1'b0;
            collision   <= 1'b1;
            death_cnt   <= CW'(DEATH_FRAMES - 1);
          end
        end
        S_DYING: begin
          if (frame_en) begin
            if (death_cnt == '0) begin
              st <= S_OVER;
              // Score is frozen outside PLAYING, so it is final here.
              if (score_bcd > high_bcd) high_bcd <= score_bcd;
            end else begin
              death_cnt <= death_cnt - 1'b1;
            end
          end
        end
        S_OVER: begin
          if (btn_flap) st <= S_IDLE;
        end
        default: st <= S_IDLE;
      endcase
    end
  end

endmodule
